rv32_fxmadd_issue: RTL and testbench

Operand-staging stage directly upstream of the fixed-point multiply-add unit in the execute stage. It accepts decoded FXMADD instructions from decode over a valid/ready handshake. It attaches the active 5-bit product shift scale, taken from either the instruction immediate or the FXSCALE CSR register held here. Accepted instructions are buffered in a small in-order FIFO, and the head entry drives the multiply-add operands and split scale fields combinationally into the arithmetic unit, with the destination tag passed on to writeback.

---
 rtl/rv32_fxmadd_issue.sv | 132 +++++++++++++
 tb/tb_rv32_fxmadd_issue.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_fxmadd_issue.sv
`default_nettype none
// ============================================================================
// Module   : rv32_fxmadd_issue
// Purpose  : Operand-staging FIFO in front of the fixed-point multiply-add
//            unit. Captures decoded FXMADD instructions together with their
//            active product shift scale (immediate or FXSCALE CSR), and
//            presents the oldest entry combinationally to the arithmetic unit.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_fxmadd_issue #(
  parameter int         DEPTH       = 2,
  parameter logic [4:0] SCALE_RESET = 5'd0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_rs1_val,
  input  logic [31:0]              in_rs2_val,
  input  logic [31:0]              in_rs3_val,
  input  logic [4:0]               in_rd,
  input  logic                     in_use_imm_scale,
  input  logic [4:0]               in_imm_scale,
  input  logic                     csr_we,
  input  logic [4:0]               csr_wdata,
  output logic [4:0]               csr_scale,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              mul_op_1,
  output logic [31:0]              mul_op_2,
  output logic [31:0]              add_op,
  output logic [2:0]               low_bits_selected_scale,
  output logic [1:0]               high_bit_selected_scale,
  output logic [4:0]               out_rd,
  output logic                     out_wb_en,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    c_depth = (AW+1)'(DEPTH);

  // Entry storage
  logic [31:0] r_rs1   [DEPTH];
  logic [31:0] r_rs2   [DEPTH];
  logic [31:0] r_rs3   [DEPTH];
  logic [4:0]  r_rd    [DEPTH];
  logic [4:0]  r_scl   [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [4:0]    r_scale;

  logic          w_push;
  logic          w_pop;
  logic [4:0]    w_scale_in;
  logic [4:0]    w_head_scale;

  // Flow control: ready depends only on stored state so no full-FIFO bypass exists
  assign in_ready   = (r_count != c_depth);
  assign out_valid  = (r_count != '0);
  assign w_push     = in_valid & in_ready & ~flush;
  assign w_pop      = out_valid & out_ready & ~flush;

  // Scale is sampled from the registered CSR so a same-cycle write does not leak in
  assign w_scale_in = in_use_imm_scale ? in_imm_scale : r_scale;

  // Pointer and occupancy tracking; flush overrides any same-cycle push/pop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry write on accept; storage cleared on reset so head outputs read zero
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rs1[i] <= '0;
        r_rs2[i] <= '0;
        r_rs3[i] <= '0;
        r_rd[i]  <= '0;
        r_scl[i] <= '0;
      end
    end else if (w_push) begin
      r_rs1[r_wr_ptr] <= in_rs1_val;
      r_rs2[r_wr_ptr] <= in_rs2_val;
      r_rs3[r_wr_ptr] <= in_rs3_val;
      r_rd[r_wr_ptr]  <= in_rd;
      r_scl[r_wr_ptr] <= w_scale_in;
    end
  end

  // FXSCALE CSR: writes land regardless of flush or FIFO fullness
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_scale <= SCALE_RESET;
    end else if (csr_we) begin
      r_scale <= csr_wdata;
    end
  end

  assign csr_scale               = r_scale;
  assign occupancy               = r_count;

  // Head entry drives the arithmetic unit directly; stale when empty
  assign mul_op_1                = r_rs1[r_rd_ptr];
  assign mul_op_2                = r_rs2[r_rd_ptr];
  assign add_op                  = r_rs3[r_rd_ptr];
  assign out_rd                  = r_rd[r_rd_ptr];
  assign w_head_scale            = r_scl[r_rd_ptr];
  assign low_bits_selected_scale = w_head_scale[2:0];
  assign high_bit_selected_scale = w_head_scale[4:3];
  assign out_wb_en               = (out_rd != 5'd0);

endmodule
`default_nettype wire

// File: tb/tb_rv32_fxmadd_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_fxmadd_issue
// Purpose  : Self-checking bench for rv32_fxmadd_issue with a queue-based
//            reference model and directed plus randomized scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_fxmadd_issue;

  localparam int         DEPTH       = 2;
  localparam logic [4:0] SCALE_RESET = 5'd3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rs1_val, in_rs2_val, in_rs3_val;
  logic [4:0]  in_rd;
  logic        in_use_imm_scale;
  logic [4:0]  in_imm_scale;
  logic        csr_we;
  logic [4:0]  csr_wdata;
  logic [4:0]  csr_scale;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] mul_op_1, mul_op_2, add_op;
  logic [2:0]  low_bits_selected_scale;
  logic [1:0]  high_bit_selected_scale;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic [$clog2(DEPTH):0] occupancy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rs3;
    logic [4:0]  rd;
    logic [4:0]  scale;
  } ent_t;

  ent_t       q[$];
  logic [4:0] m_scale;

  rv32_fxmadd_issue #(.DEPTH(DEPTH), .SCALE_RESET(SCALE_RESET)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_rs3_val(in_rs3_val),
    .in_rd(in_rd), .in_use_imm_scale(in_use_imm_scale), .in_imm_scale(in_imm_scale),
    .csr_we(csr_we), .csr_wdata(csr_wdata), .csr_scale(csr_scale),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .mul_op_1(mul_op_1), .mul_op_2(mul_op_2), .add_op(add_op),
    .low_bits_selected_scale(low_bits_selected_scale),
    .high_bit_selected_scale(high_bit_selected_scale),
    .out_rd(out_rd), .out_wb_en(out_wb_en), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    in_valid = 0; in_rs1_val = '0; in_rs2_val = '0; in_rs3_val = '0;
    in_rd = '0; in_use_imm_scale = 0; in_imm_scale = '0;
    csr_we = 0; csr_wdata = '0; flush = 0; out_ready = 0;
  endtask

  task automatic drive_op(input logic [4:0] rd, input logic use_imm, input logic [4:0] imm);
    in_valid = 1; in_rd = rd; in_use_imm_scale = use_imm; in_imm_scale = imm;
    in_rs1_val = $urandom; in_rs2_val = $urandom; in_rs3_val = $urandom;
  endtask

  // Advance one clock, updating the reference model from the inputs seen at the edge
  task automatic tick();
    bit   acc, pop;
    ent_t e;
    acc = in_valid && (q.size() != DEPTH) && !flush;
    pop = (q.size() != 0) && out_ready && !flush;
    e.rs1 = in_rs1_val; e.rs2 = in_rs2_val; e.rs3 = in_rs3_val; e.rd = in_rd;
    e.scale = in_use_imm_scale ? in_imm_scale : m_scale;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pop) q.delete(0);
      if (acc) q.push_back(e);
    end
    if (csr_we) m_scale = csr_wdata;
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rstn = 0;
    q.delete();
    m_scale = SCALE_RESET;
    #12;
    checks++;
    if (occupancy !== 0 || out_valid !== 0 || csr_scale !== SCALE_RESET) begin
      errors++;
      $display("FAIL reset_state: occ=%0d ov=%0b csr=%0d, want occ=0 ov=0 csr=%0d",
               occupancy, out_valid, csr_scale, SCALE_RESET);
    end
    checks++;
    if (mul_op_1 !== 0 || mul_op_2 !== 0 || add_op !== 0 || out_rd !== 0 ||
        low_bits_selected_scale !== 0 || high_bit_selected_scale !== 0) begin
      errors++;
      $display("FAIL reset_head: op1=%h op2=%h add=%h rd=%0d, want all zero",
               mul_op_1, mul_op_2, add_op, out_rd);
    end
    @(posedge clk); #1;
    rstn = 1;
    checks++;
    if (in_ready !== 1 || occupancy !== 0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%0b occ=%0d, want 1 and 0", in_ready, occupancy);
    end
  endtask

  task automatic test_single_op();
    drive_idle();
    in_valid = 1; in_rs1_val = 32'h0003_0000; in_rs2_val = 32'h0002_0000;
    in_rs3_val = 32'd5; in_use_imm_scale = 1; in_imm_scale = 5'd16; in_rd = 5'd7;
    out_ready = 1;
    tick();
    in_valid = 0;
    checks++;
    if (out_valid !== 1 || mul_op_1 !== 32'h0003_0000 || mul_op_2 !== 32'h0002_0000 ||
        add_op !== 32'd5 || low_bits_selected_scale !== 3'b000 ||
        high_bit_selected_scale !== 2'b10 || out_rd !== 5'd7 || out_wb_en !== 1) begin
      errors++;
      $display("FAIL single_op: ov=%0b op1=%h op2=%h add=%h lo=%0d hi=%0d rd=%0d wb=%0b, want 1 30000 20000 5 0 2 7 1",
               out_valid, mul_op_1, mul_op_2, add_op, low_bits_selected_scale,
               high_bit_selected_scale, out_rd, out_wb_en);
    end
    tick();
    checks++;
    if (out_valid !== 0) begin
      errors++;
      $display("FAIL single_op_drain: out_valid=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] got[$];
    bit acc;
    drive_idle();
    drive_op(5'd1, 1, 5'd0); tick();
    drive_op(5'd2, 1, 5'd0); tick();
    drive_op(5'd3, 1, 5'd0);
    tick();
    checks++;
    if (in_ready !== 0 || occupancy !== 2) begin
      errors++;
      $display("FAIL backpressure_full: in_ready=%0b occ=%0d, want 0 and 2", in_ready, occupancy);
    end
    out_ready = 1;
    for (int i = 0; i < 10 && got.size() < 3; i++) begin
      if (out_valid && out_ready) got.push_back(out_rd);
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 0;
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL backpressure_count: got %0d heads, want 3", got.size());
    end else if (got[0] !== 5'd1 || got[1] !== 5'd2 || got[2] !== 5'd3) begin
      errors++;
      $display("FAIL backpressure_order: got %0d,%0d,%0d want 1,2,3", got[0], got[1], got[2]);
    end
    checks++;
    if (out_valid !== 0 || occupancy !== 0) begin
      errors++;
      $display("FAIL backpressure_dup: ov=%0b occ=%0d, want 0 and 0", out_valid, occupancy);
    end
    drive_idle();
  endtask

  task automatic test_csr_timing();
    drive_idle();
    csr_we = 1; csr_wdata = 5'd4; tick();
    csr_we = 0;
    checks++;
    if (csr_scale !== 5'd4) begin
      errors++;
      $display("FAIL csr_write: csr_scale=%0d, want 4", csr_scale);
    end
    csr_we = 1; csr_wdata = 5'd9; drive_op(5'd10, 0, 5'd31);
    tick();
    csr_we = 0;
    checks++;
    if (csr_scale !== 5'd9) begin
      errors++;
      $display("FAIL csr_next_cycle: csr_scale=%0d, want 9", csr_scale);
    end
    drive_op(5'd11, 0, 5'd31);
    tick();
    in_valid = 0;
    checks++;
    if (out_rd !== 5'd10 || low_bits_selected_scale !== 3'd4 || high_bit_selected_scale !== 2'd0) begin
      errors++;
      $display("FAIL csr_scale_A: rd=%0d lo=%0d hi=%0d, want 10 4 0",
               out_rd, low_bits_selected_scale, high_bit_selected_scale);
    end
    out_ready = 1;
    tick();
    checks++;
    if (out_valid !== 1 || out_rd !== 5'd11 || low_bits_selected_scale !== 3'd1 ||
        high_bit_selected_scale !== 2'd1) begin
      errors++;
      $display("FAIL csr_scale_B: ov=%0b rd=%0d lo=%0d hi=%0d, want 1 11 1 1",
               out_valid, out_rd, low_bits_selected_scale, high_bit_selected_scale);
    end
    tick();
    drive_idle();
  endtask

  task automatic test_flush();
    drive_idle();
    drive_op(5'd5, 1, 5'd2); tick();
    drive_op(5'd6, 1, 5'd2); tick();
    drive_op(5'd9, 1, 5'd2); flush = 1; out_ready = 1;
    tick();
    flush = 0; in_valid = 0; out_ready = 0;
    checks++;
    if (occupancy !== 0 || out_valid !== 0 || in_ready !== 1) begin
      errors++;
      $display("FAIL flush_clear: occ=%0d ov=%0b ir=%0b, want 0 0 1", occupancy, out_valid, in_ready);
    end
    tick();
    checks++;
    if (occupancy !== 0) begin
      errors++;
      $display("FAIL flush_no_capture: occ=%0d, want 0", occupancy);
    end
    drive_op(5'd21, 1, 5'd8); tick();
    in_valid = 0;
    checks++;
    if (out_valid !== 1 || out_rd !== 5'd21 || high_bit_selected_scale !== 2'd1) begin
      errors++;
      $display("FAIL flush_after_push: ov=%0b rd=%0d hi=%0d, want 1 21 1",
               out_valid, out_rd, high_bit_selected_scale);
    end
    out_ready = 1; tick();
    drive_idle();
  endtask

  task automatic test_rd_zero();
    drive_idle();
    drive_op(5'd0, 1, 5'd1); tick();
    in_valid = 0;
    checks++;
    if (out_valid !== 1 || out_wb_en !== 0 || out_rd !== 0) begin
      errors++;
      $display("FAIL rd_zero: ov=%0b wb=%0b rd=%0d, want 1 0 0", out_valid, out_wb_en, out_rd);
    end
    out_ready = 1; tick();
    drive_idle();
  endtask

  task automatic test_simul_push_pop();
    drive_idle();
    drive_op(5'd12, 1, 5'd0); tick();
    drive_op(5'd13, 1, 5'd0); out_ready = 1;
    checks++;
    if (occupancy !== 1 || out_rd !== 5'd12) begin
      errors++;
      $display("FAIL simul_pre: occ=%0d rd=%0d, want 1 12", occupancy, out_rd);
    end
    tick();
    in_valid = 0;
    checks++;
    if (occupancy !== 1 || out_rd !== 5'd13 || out_valid !== 1) begin
      errors++;
      $display("FAIL simul_push_pop: occ=%0d rd=%0d ov=%0b, want 1 13 1", occupancy, out_rd, out_valid);
    end
    tick();
    drive_idle();
  endtask

  task automatic test_async_reset();
    drive_idle();
    csr_we = 1; csr_wdata = 5'd17;
    drive_op(5'd14, 0, 5'd0); tick();
    csr_we = 0;
    drive_op(5'd15, 0, 5'd0); tick();
    in_valid = 0;
    checks++;
    if (occupancy !== 2 || csr_scale !== 5'd17) begin
      errors++;
      $display("FAIL async_pre: occ=%0d csr=%0d, want 2 17", occupancy, csr_scale);
    end
    @(posedge clk); #3;
    rstn = 0;
    #1;
    q.delete();
    m_scale = SCALE_RESET;
    checks++;
    if (out_valid !== 0 || occupancy !== 0 || csr_scale !== SCALE_RESET || out_rd !== 0) begin
      errors++;
      $display("FAIL async_reset: ov=%0b occ=%0d csr=%0d rd=%0d, want 0 0 %0d 0",
               out_valid, occupancy, csr_scale, out_rd, SCALE_RESET);
    end
    @(posedge clk); #1;
    rstn = 1;
    @(posedge clk); #1;
    checks++;
    if (occupancy !== 0 || in_ready !== 1 || out_valid !== 0) begin
      errors++;
      $display("FAIL async_release: occ=%0d ir=%0b ov=%0b, want 0 1 0", occupancy, in_ready, out_valid);
    end
  endtask

  task automatic test_random();
    drive_idle();
    for (int i = 0; i < 500; i++) begin
      in_valid         = ($urandom_range(0, 9) < 7);
      out_ready        = ($urandom_range(0, 9) < 6);
      flush            = ($urandom_range(0, 19) == 0);
      csr_we           = ($urandom_range(0, 6) == 0);
      csr_wdata        = 5'($urandom);
      in_rs1_val       = $urandom; in_rs2_val = $urandom; in_rs3_val = $urandom;
      in_rd            = 5'($urandom);
      in_use_imm_scale = $urandom_range(0, 1);
      in_imm_scale     = 5'($urandom);
      #1;
      checks++;
      if (occupancy !== q.size() || out_valid !== (q.size() != 0) ||
          in_ready !== (q.size() != DEPTH) || csr_scale !== m_scale) begin
        errors++;
        $display("FAIL rand_state[%0d]: occ=%0d ov=%0b ir=%0b csr=%0d, want occ=%0d csr=%0d",
                 i, occupancy, out_valid, in_ready, csr_scale, q.size(), m_scale);
      end
      if (q.size() != 0) begin
        checks++;
        if (mul_op_1 !== q[0].rs1 || mul_op_2 !== q[0].rs2 || add_op !== q[0].rs3 ||
            out_rd !== q[0].rd || {high_bit_selected_scale, low_bits_selected_scale} !== q[0].scale ||
            out_wb_en !== (q[0].rd != 0)) begin
          errors++;
          $display("FAIL rand_head[%0d]: op1=%h op2=%h add=%h rd=%0d scale=%0d, want %h %h %h %0d %0d",
                   i, mul_op_1, mul_op_2, add_op, out_rd,
                   {high_bit_selected_scale, low_bits_selected_scale},
                   q[0].rs1, q[0].rs2, q[0].rs3, q[0].rd, q[0].scale);
        end
      end
      tick();
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_back_to_back();
    test_csr_timing();
    test_flush();
    test_rd_zero();
    test_simul_push_pop();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
